// File: rtl/mest_pro_pkg.sv
// Shared types and default widths for the MEST Pro program-memory subsystem.
//   owner_e   : which requester owns a memory transaction
//   mem_tag_t : response-routing tag carried alongside each read command
package mest_pro_pkg;

  localparam int unsigned OP_CODE_SIZE = 4;
  localparam int unsigned ROM_DEPTH    = 65536;
  localparam int unsigned ADDR_W_DEF   = $clog2(ROM_DEPTH);
  localparam int unsigned DATA_W_DEF   = OP_CODE_SIZE + 24;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } mem_tag_t;

endpackage

// File: rtl/mest_pro_resp_pipe.sv
// Response path: delays read tags by MEM_LATENCY cycles so that each tag lines
// up with its i_mem_rdata, then registers data/error into the owner's outputs.
//   i_tag                  : tag issued in the memory command cycle
//   i_mem_rdata/i_mem_error: memory response, MEM_LATENCY cycles after command
//   o_core_* / o_host_*    : registered read data, strobe and error per owner
//   o_err_count            : saturating count of errored reads (both owners)
module mest_pro_resp_pipe
  import mest_pro_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  mem_tag_t          i_tag,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_error,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_rvalid,
  output logic              o_core_err,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_host_rvalid,
  output logic              o_host_err,
  output logic [7:0]        o_err_count
);

  mem_tag_t [MEM_LATENCY-1:0] r_stage;
  mem_tag_t                   w_out;
  logic                       w_core_hit;
  logic                       w_host_hit;

  // Tag shift register; stage MEM_LATENCY-1 is aligned with i_mem_rdata.
  if (MEM_LATENCY > 1) begin : g_deep
    always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) r_stage <= '0;
      else            r_stage <= {r_stage[MEM_LATENCY-2:0], i_tag};
    end
  end else begin : g_one
    always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) r_stage <= '0;
      else            r_stage <= i_tag;
    end
  end

  assign w_out      = r_stage[MEM_LATENCY-1];
  assign w_core_hit = w_out.valid && (w_out.owner == OWN_CORE);
  assign w_host_hit = w_out.valid && (w_out.owner == OWN_HOST);

  // Demux the emerging response; rdata holds between strobes, err only with rvalid.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_core_rdata  <= '0;
      o_core_rvalid <= 1'b0;
      o_core_err    <= 1'b0;
      o_host_rdata  <= '0;
      o_host_rvalid <= 1'b0;
      o_host_err    <= 1'b0;
      o_err_count   <= '0;
    end else begin
      o_core_rvalid <= w_core_hit;
      o_core_err    <= w_core_hit & i_mem_error;
      o_host_rvalid <= w_host_hit;
      o_host_err    <= w_host_hit & i_mem_error;
      if (w_core_hit) o_core_rdata <= i_mem_rdata;
      if (w_host_hit) o_host_rdata <= i_mem_rdata;
      if (w_out.valid && i_mem_error && (o_err_count != 8'hFF))
        o_err_count <= o_err_count + 8'd1;
    end
  end

endmodule

// File: rtl/mest_pro_mem_arbiter.sv
// Arbitrates one single-port program memory between the core fetch unit
// (read-only) and the host/loader port (read/write).
//   i_core_* / o_core_gnt : core request, combinational grant
//   i_host_* / o_host_gnt : host request (we/lock/addr/wdata), combinational grant
//   o_mem_*               : registered memory command, one cycle after grant
//   i_mem_rdata/error     : memory response, MEM_LATENCY cycles after command
//   o_core_r*/o_host_r*   : routed, registered read responses
//   o_err_count           : saturating count of errored reads
module mest_pro_mem_arbiter
  import mest_pro_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned LOCK_MAX    = 16
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_core_req,
  input  logic [ADDR_W-1:0] i_core_addr,
  output logic              o_core_gnt,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_rvalid,
  output logic              o_core_err,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic              i_host_lock,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_gnt,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_host_rvalid,
  output logic              o_host_err,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_error,
  output logic [7:0]        o_err_count
);

  localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

  owner_e            r_rr_ptr;
  logic              r_last_host;
  logic [LOCK_W-1:0] r_lock_cnt;
  mem_tag_t          r_cmd_tag;
  logic              w_core_gnt;
  logic              w_host_gnt;
  logic              w_lock_win;

  // Grant selection: single requester wins; on contention the lock or the rr pointer decides.
  always_comb begin
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    w_lock_win = i_host_lock & i_host_req & r_last_host &
                 (r_lock_cnt < LOCK_W'(LOCK_MAX));
    if (i_core_req && i_host_req) begin
      if (w_lock_win || (r_rr_ptr == OWN_HOST)) w_host_gnt = 1'b1;
      else                                      w_core_gnt = 1'b1;
    end else begin
      w_core_gnt = i_core_req;
      w_host_gnt = i_host_req;
    end
  end

  assign o_core_gnt = w_core_gnt;
  assign o_host_gnt = w_host_gnt;

  // Round-robin pointer and lock counter. The first locked grant counts, so a
  // burst gets LOCK_MAX consecutive slots before the core is let in.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rr_ptr    <= OWN_CORE;
      r_last_host <= 1'b0;
      r_lock_cnt  <= '0;
    end else begin
      if (w_core_gnt)      r_rr_ptr <= OWN_HOST;
      else if (w_host_gnt) r_rr_ptr <= OWN_CORE;
      r_last_host <= w_host_gnt;
      if (w_host_gnt && i_host_lock) begin
        if (r_lock_cnt != LOCK_W'(LOCK_MAX)) r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
      end else begin
        r_lock_cnt <= '0;
      end
    end
  end

  // Registered memory command plus the read tag issued in the same cycle.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mem_cs    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      r_cmd_tag   <= '{valid: 1'b0, owner: OWN_CORE};
    end else begin
      o_mem_cs    <= w_core_gnt | w_host_gnt;
      o_mem_we    <= w_host_gnt & i_host_we;
      o_mem_addr  <= w_host_gnt ? i_host_addr : (w_core_gnt ? i_core_addr : '0);
      o_mem_wdata <= (w_host_gnt && i_host_we) ? i_host_wdata : '0;
      r_cmd_tag   <= '{valid: w_core_gnt | (w_host_gnt & ~i_host_we),
                       owner: (w_host_gnt ? OWN_HOST : OWN_CORE)};
    end
  end

  mest_pro_resp_pipe #(
    .DATA_W      (DATA_W),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_resp_pipe (
    .clk           (clk),
    .i_reset_n     (i_reset_n),
    .i_tag         (r_cmd_tag),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_error   (i_mem_error),
    .o_core_rdata  (o_core_rdata),
    .o_core_rvalid (o_core_rvalid),
    .o_core_err    (o_core_err),
    .o_host_rdata  (o_host_rdata),
    .o_host_rvalid (o_host_rvalid),
    .o_host_err    (o_host_err),
    .o_err_count   (o_err_count)
  );

endmodule

// File: tb/tb_mest_pro_mem_arbiter.sv
// Bench for mest_pro_mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model (grant rules, a
// reference memory and a queue of expected responses).
module tb_mest_pro_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 28;
  localparam int LAT  = 1;
  localparam int LOCK = 16;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_core_req;
  logic [AW-1:0] i_core_addr;
  logic          o_core_gnt;
  logic [DW-1:0] o_core_rdata;
  logic          o_core_rvalid;
  logic          o_core_err;
  logic          i_host_req;
  logic          i_host_we;
  logic          i_host_lock;
  logic [AW-1:0] i_host_addr;
  logic [DW-1:0] i_host_wdata;
  logic          o_host_gnt;
  logic [DW-1:0] o_host_rdata;
  logic          o_host_rvalid;
  logic          o_host_err;
  logic          o_mem_cs;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_error;
  logic [7:0]    o_err_count;

  always #5 clk = ~clk;

  mest_pro_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .LOCK_MAX(LOCK)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .i_core_req(i_core_req), .i_core_addr(i_core_addr), .o_core_gnt(o_core_gnt),
    .o_core_rdata(o_core_rdata), .o_core_rvalid(o_core_rvalid), .o_core_err(o_core_err),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_lock(i_host_lock),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt),
    .o_host_rdata(o_host_rdata), .o_host_rvalid(o_host_rvalid), .o_host_err(o_host_err),
    .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_error(i_mem_error),
    .o_err_count(o_err_count)
  );

  typedef struct {
    int            due;
    bit            host;
    logic [DW-1:0] data;
    bit            err;
  } resp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] env_mem   [logic [AW-1:0]];
  resp_t         exp_q[$];
  bit            glog[$];
  bit            m_turn_host, m_prev_host;
  int            m_streak, m_errcnt;
  bit            p_cs, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  bit            g_core, g_host;
  logic          obs_core_gnt;
  logic [DW-1:0] d_data [LAT];
  bit            d_err  [LAT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Unwritten memory contents are a fixed function of the address.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a[11:0], ~a};
  endfunction

  // Region 0xE000-0xEFFF of the memory reports an error on every read.
  function automatic bit is_err_addr(input logic [AW-1:0] a);
    return a[15:12] == 4'hE;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return {4'hE, 12'($urandom_range(0, 15))};
    return AW'($urandom_range(0, 31));
  endfunction

  task automatic model_reset();
    m_turn_host = 1'b0;
    m_prev_host = 1'b0;
    m_streak    = 0;
    m_errcnt    = 0;
    exp_q.delete();
    p_cs = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
  endtask

  task automatic chk_reset_state();
    chk("rst_core_gnt",    32'(o_core_gnt), 32'd0);
    chk("rst_host_gnt",    32'(o_host_gnt), 32'd0);
    chk("rst_core_rdata",  32'(o_core_rdata), 32'd0);
    chk("rst_core_rvalid", 32'(o_core_rvalid), 32'd0);
    chk("rst_core_err",    32'(o_core_err), 32'd0);
    chk("rst_host_rdata",  32'(o_host_rdata), 32'd0);
    chk("rst_host_rvalid", 32'(o_host_rvalid), 32'd0);
    chk("rst_host_err",    32'(o_host_err), 32'd0);
    chk("rst_mem_cs",      32'(o_mem_cs), 32'd0);
    chk("rst_mem_we",      32'(o_mem_we), 32'd0);
    chk("rst_mem_addr",    32'(o_mem_addr), 32'd0);
    chk("rst_mem_wdata",   32'(o_mem_wdata), 32'd0);
    chk("rst_err_count",   32'(o_err_count), 32'd0);
  endtask

  // One clock cycle: check the command bus, play the memory, check responses
  // and grants against the model, then advance past the next rising edge.
  task automatic tick();
    resp_t r;
    bit ec, eh, ee, lockwin;
    logic [DW-1:0] ed;
    @(negedge clk);
    chk("mem_cs", 32'(o_mem_cs), 32'(p_cs));
    if (p_cs) begin
      chk("mem_we",   32'(o_mem_we), 32'(p_we));
      chk("mem_addr", 32'(o_mem_addr), 32'(p_addr));
      if (p_we) chk("mem_wdata", 32'(o_mem_wdata), 32'(p_wdata));
    end else begin
      chk("idle_we",    32'(o_mem_we), 32'd0);
      chk("idle_addr",  32'(o_mem_addr), 32'd0);
      chk("idle_wdata", 32'(o_mem_wdata), 32'd0);
    end
    if (o_mem_cs && o_mem_we) env_mem[o_mem_addr] = o_mem_wdata;
    if (o_mem_cs && !o_mem_we) begin
      d_data[LAT-1] = env_rd(o_mem_addr);
      d_err[LAT-1]  = is_err_addr(o_mem_addr);
    end else begin
      d_data[LAT-1] = DW'($urandom);
      d_err[LAT-1]  = 1'($urandom);
    end
    ec = 1'b0; eh = 1'b0; ee = 1'b0; ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r  = exp_q.pop_front();
      ec = !r.host; eh = r.host; ed = r.data; ee = r.err;
      if (ee && m_errcnt < 255) m_errcnt++;
    end
    chk("core_rvalid", 32'(o_core_rvalid), 32'(ec));
    chk("host_rvalid", 32'(o_host_rvalid), 32'(eh));
    chk("core_err",    32'(o_core_err), 32'(ec && ee));
    chk("host_err",    32'(o_host_err), 32'(eh && ee));
    if (ec) chk("core_rdata", 32'(o_core_rdata), 32'(ed));
    if (eh) chk("host_rdata", 32'(o_host_rdata), 32'(ed));
    chk("err_count", 32'(o_err_count), 32'(m_errcnt));
    g_core = 1'b0; g_host = 1'b0;
    if (i_core_req && i_host_req) begin
      lockwin = i_host_lock && m_prev_host && (m_streak < LOCK);
      g_host  = lockwin || m_turn_host;
      g_core  = !g_host;
    end else begin
      g_core = i_core_req;
      g_host = i_host_req;
    end
    obs_core_gnt = o_core_gnt;
    chk("core_gnt", 32'(o_core_gnt), 32'(g_core));
    chk("host_gnt", 32'(o_host_gnt), 32'(g_host));
    p_cs = g_core || g_host; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    if (g_core) begin
      p_addr = i_core_addr;
      exp_q.push_back('{cyc + LAT + 2, 1'b0, model_rd(i_core_addr), is_err_addr(i_core_addr)});
    end else if (g_host) begin
      p_addr = i_host_addr;
      p_we   = i_host_we;
      if (i_host_we) begin
        p_wdata = i_host_wdata;
        model_mem[i_host_addr] = i_host_wdata;
      end else begin
        exp_q.push_back('{cyc + LAT + 2, 1'b1, model_rd(i_host_addr), is_err_addr(i_host_addr)});
      end
    end
    if (g_core || g_host) begin
      glog.push_back(g_host);
      m_turn_host = !g_host;
    end
    m_streak    = (g_host && i_host_lock) ? m_streak + 1 : 0;
    m_prev_host = g_host;
    @(posedge clk);
    #1;
    cyc++;
    i_mem_rdata = d_data[0];
    i_mem_error = d_err[0];
    for (int i = 0; i < LAT - 1; i++) begin
      d_data[i] = d_data[i+1];
      d_err[i]  = d_err[i+1];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit core_pend, host_pend;
    int host_cnt, guard, f;

    i_reset_n = 1'b0;
    i_core_req = 1'b0; i_core_addr = '0;
    i_host_req = 1'b0; i_host_we = 1'b0; i_host_lock = 1'b0;
    i_host_addr = '0; i_host_wdata = '0;
    i_mem_rdata = '0; i_mem_error = 1'b0;
    for (int i = 0; i < LAT; i++) begin d_data[i] = '0; d_err[i] = 1'b0; end
    model_reset();
    #2;
    chk_reset_state();
    tick(); tick();
    i_reset_n = 1'b1;

    // Both requesters contend: grants alternate starting with the core.
    glog.delete();
    i_core_req = 1'b1; i_core_addr = 16'h0020;
    i_host_req = 1'b1; i_host_addr = 16'h0040;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (g_core) i_core_addr = 16'h0021 + 16'(k);
      if (g_host) i_host_addr = 16'h0041 + 16'(k);
    end
    i_core_req = 1'b0; i_host_req = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) chk("alternate", 32'(glog[i]), 32'(i % 2));

    // Core alone reads a known word.
    model_mem[16'h0005] = 28'h0ABCDEF;
    env_mem[16'h0005]   = 28'h0ABCDEF;
    i_core_req = 1'b1; i_core_addr = 16'h0005;
    tick();
    i_core_req = 1'b0;
    repeat (4) tick();
    chk("single_core_rdata", 32'(o_core_rdata), 32'h0ABCDEF);

    // Locked host write burst of 20 against a continuously requesting core.
    repeat (3) tick();
    glog.delete();
    i_core_req = 1'b1; i_core_addr = 16'h0060;
    i_host_req = 1'b1; i_host_we = 1'b1; i_host_lock = 1'b1;
    i_host_addr = 16'h0100; i_host_wdata = DW'($urandom);
    host_cnt = 0; guard = 0;
    while (host_cnt < 20 && guard < 100) begin
      tick();
      guard++;
      if (g_core) i_core_addr = i_core_addr + 16'd1;
      if (g_host) begin
        host_cnt++;
        i_host_addr  = 16'h0100 + 16'(host_cnt);
        i_host_wdata = DW'($urandom);
        if (host_cnt == 20) begin i_host_req = 1'b0; i_host_lock = 1'b0; end
      end
    end
    i_core_req = 1'b0; i_host_we = 1'b0;
    repeat (4) tick();
    chk("burst_done", 32'(guard < 100), 32'd1);
    f = -1;
    for (int i = 0; i < glog.size(); i++) if (glog[i] && f < 0) f = i;
    if (f < 0 || glog.size() < f + 18) begin
      chk("burst_len", 32'(glog.size()), 32'(f + 18));
    end else begin
      for (int i = 0; i < 16; i++) chk("burst_host_run", 32'(glog[f+i]), 32'd1);
      chk("burst_core_slot", 32'(glog[f+16]), 32'd0);
      chk("burst_host_resume", 32'(glog[f+17]), 32'd1);
    end

    // Host write then core read of the same address.
    i_host_req = 1'b1; i_host_we = 1'b1; i_host_addr = 16'h0010; i_host_wdata = 28'h1234567;
    tick();
    i_host_req = 1'b0; i_host_we = 1'b0;
    i_core_req = 1'b1; i_core_addr = 16'h0010;
    tick();
    i_core_req = 1'b0;
    repeat (4) tick();
    chk("raw_core_rdata", 32'(o_core_rdata), 32'h1234567);

    // Randomized traffic; requests held until granted.
    core_pend = 1'b0; host_pend = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      tick();
      if (g_core) core_pend = 1'b0;
      if (g_host) host_pend = 1'b0;
      if (!core_pend && $urandom_range(0, 2) != 0) begin
        core_pend = 1'b1; i_core_addr = rand_addr();
      end
      if (!host_pend && $urandom_range(0, 2) != 0) begin
        host_pend    = 1'b1;
        i_host_addr  = rand_addr();
        i_host_we    = 1'($urandom);
        i_host_lock  = $urandom_range(0, 3) != 0;
        i_host_wdata = DW'($urandom);
      end
      i_core_req = core_pend;
      i_host_req = host_pend;
    end
    i_core_req = 1'b0; i_host_req = 1'b0; i_host_lock = 1'b0; i_host_we = 1'b0;
    repeat (5) tick();

    // Reset with a core read in flight: dropped, and pointer back to the core.
    i_core_req = 1'b1; i_core_addr = 16'h0003;
    tick();
    i_core_req = 1'b0;
    tick();
    i_reset_n = 1'b0;
    #1;
    chk_reset_state();
    model_reset();
    tick(); tick();
    i_reset_n = 1'b1;
    repeat (4) tick();
    i_core_req = 1'b1; i_core_addr = 16'h0007;
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_lock = 1'b1; i_host_addr = 16'h0008;
    tick();
    chk("post_reset_core_first", 32'(obs_core_gnt), 32'd1);
    i_core_req = 1'b0;
    tick();
    i_host_req = 1'b0; i_host_lock = 1'b0;
    repeat (4) tick();

    // Errored host reads: count starts at one, then saturates.
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 16'hE005;
    tick();
    i_host_req = 1'b0;
    repeat (4) tick();
    chk("err_count_one", 32'(o_err_count), 32'd1);
    i_host_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      i_host_addr = 16'hE000 | 16'(k & 12'hFFF);
      tick();
    end
    i_host_req = 1'b0;
    repeat (5) tick();
    chk("err_count_sat", 32'(o_err_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mest_pro_mem_arbiter.md
Name: mest_pro_mem_arbiter

Overview:
- Shares one single-port program memory between two requesters: the core fetch unit (requester 0, read-only) and a host/loader port (requester 1, read/write).
- Arbitration is round-robin with a bounded host lock for burst program loads.
- Commands are issued registered and in order; read data and errors are routed back to the owning requester through a tag pipeline.
- Sits between the MEST Pro core's o_req/o_prog_counter/i_instruction interface and the memory macro.

Parameters:
ADDR_W, 16, memory address width (clog2 of ROM_DEPTH)
DATA_W, 28, instruction word width (OP_CODE_SIZE+24)
MEM_LATENCY, 1, cycles from command cycle to valid i_mem_rdata (range 1..4)
LOCK_MAX, 16, max consecutive locked host grants before the core is forced one slot

Ports:
clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_core_req  in  1  core read request, held with i_core_addr until o_core_gnt
i_core_addr  in  ADDR_W  core read address
o_core_gnt  out  1  combinational grant for the core
o_core_rdata  out  DATA_W  registered read data
o_core_rvalid  out  1  one-cycle read-data strobe
o_core_err  out  1  memory error flag accompanying o_core_rvalid
i_host_req  in  1  host request, held stable until o_host_gnt
i_host_we  in  1  1=write, 0=read
i_host_lock  in  1  request to keep the grant on consecutive host requests
i_host_addr  in  ADDR_W  host address
i_host_wdata  in  DATA_W  host write data
o_host_gnt  out  1  combinational grant for the host
o_host_rdata  out  DATA_W  registered read data
o_host_rvalid  out  1  one-cycle read-data strobe, reads only
o_host_err  out  1  memory error flag accompanying o_host_rvalid
o_mem_cs  out  1  registered memory command valid
o_mem_we  out  1  registered write enable
o_mem_addr  out  ADDR_W  registered address
o_mem_wdata  out  DATA_W  registered write data
i_mem_rdata  in  DATA_W  read data, valid MEM_LATENCY cycles after command cycle
i_mem_error  in  1  error, sampled alongside i_mem_rdata
o_err_count  out  8  saturating count of errored reads, both owners

Behaviour:
- Reset (async assert): all outputs 0; tag pipeline cleared; rr pointer favours the core; lock counter 0. Responses in flight at reset are dropped and never strobed after reset releases.
- Grant is at most one per cycle, combinational from the requests and registered state.
  - Only one request active: it is granted.
  - Both requests active: the pointer side wins. The pointer flips to the other side after every grant.
- Lock rule: host wins over the core when all of these hold: i_host_lock=1, i_host_req=1, host held the previous grant, and lock_cnt < LOCK_MAX.
  - lock_cnt increments on each locked host grant and clears on any core grant or any cycle without a host grant.
  - When lock_cnt == LOCK_MAX and the core is requesting, the core takes the next slot.
- Command timing: grant in cycle N produces o_mem_cs=1 and we/addr/wdata in cycle N+1. With no grant, o_mem_cs=0 and we/addr/wdata are 0. A core grant always drives we=0.
- Response path:
  - A tag {valid, owner} is pushed for each read command and shifts through a MEM_LATENCY-deep pipeline.
  - When a tag emerges, i_mem_rdata and i_mem_error are registered into the owner's rdata/err and its rvalid pulses.
  - Read latency from grant to rvalid is MEM_LATENCY+2 cycles (3 at default). Responses return in order, full throughput (one read per cycle).
- Writes push no tag and produce no rvalid. A host write followed by a read of the same address returns the new data, because memory is in-order.
- rdata holds its last value between strobes. err is valid only with rvalid and is 0 otherwise.
- o_err_count increments on each tag emerging with i_mem_error=1 and saturates at 255.
- Simultaneous events:
  - A grant and a response emerging in the same cycle are independent.
  - Core and host responses never collide, because each cycle carries a single tag.

Decomposition:
- Shared package mest_pro_pkg holds: owner_e typedef (OWN_CORE=0, OWN_HOST=1), mem_tag_t struct {valid, owner}, and the default ADDR_W/DATA_W constants derived from OP_CODE_SIZE.
- One sub-module, mest_pro_resp_pipe: the parameterised MEM_LATENCY tag shift register plus response demux/registering.
- Arbitration and lock counter stay in the top.

Test Plan:
- Core alone reads addr 0x0005, mem returns 0x0ABCDEF → o_mem_cs/o_mem_addr=0x0005 one cycle after grant; o_core_rvalid with 0x0ABCDEF 3 cycles after grant; host outputs stay 0.
- Both request continuously → grants alternate core, host, core, host starting with core after reset; each rvalid matches its own address data.
- Host locked write burst of 20 while core requests → 16 consecutive host grants, then 1 core grant, then the host resumes. Writes produce no rvalid; o_mem_we=1 on host slots.
- Host writes 0x1234567 to 0x0010, then core reads 0x0010 → core receives 0x1234567.
- i_mem_error=1 on a host read response → o_host_err=1 with o_host_rvalid and o_err_count=1. After 300 errors the count stays 255.
- Reset asserted with 1 read in flight → outputs 0 immediately; no rvalid after release; first post-reset contested grant goes to the core.
